// File: rtl/demux8x32_buf.sv
// Registered 1-to-8 word demultiplexer: one valid/ready producer fans out into
// eight one-entry holding registers, each drained by its own consumer.

module demux8x32_buf_chan #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic             i_drain,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A write wins over a same-cycle drain: the new word replaces the old one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

module demux8x32_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       SEL,
  input  logic [WIDTH-1:0] data_in,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [WIDTH-1:0] data_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic [WIDTH-1:0] data_out2,
  output logic [WIDTH-1:0] data_out3,
  output logic [WIDTH-1:0] data_out4,
  output logic [WIDTH-1:0] data_out5,
  output logic [WIDTH-1:0] data_out6,
  output logic [WIDTH-1:0] data_out7,
  output logic [CNT_W-1:0] accept_count
);
  localparam int NUM_LANES = 8;

  logic [NUM_LANES-1:0]            w_valid;
  logic [NUM_LANES-1:0]            w_wr;
  logic [NUM_LANES-1:0]            w_drain;
  logic [NUM_LANES-1:0][WIDTH-1:0] w_data;
  logic                            w_acc;
  logic [CNT_W-1:0]                r_cnt;

  // Ready depends only on the target channel, never on in_valid.
  assign in_ready = ~w_valid[SEL] | out_ready[SEL];
  assign w_acc    = in_valid & in_ready;
  assign w_drain  = w_valid & out_ready;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign w_wr[k] = w_acc && (SEL == 3'(k));
      demux8x32_buf_chan #(.WIDTH(WIDTH)) u_chan (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr[k]),
        .i_drain (w_drain[k]),
        .i_data  (data_in),
        .o_valid (w_valid[k]),
        .o_data  (w_data[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (w_acc) r_cnt <= r_cnt + 1'b1;
  end

  assign accept_count = r_cnt;
  assign out_valid    = w_valid;
  assign data_out0    = w_data[0];
  assign data_out1    = w_data[1];
  assign data_out2    = w_data[2];
  assign data_out3    = w_data[3];
  assign data_out4    = w_data[4];
  assign data_out5    = w_data[5];
  assign data_out6    = w_data[6];
  assign data_out7    = w_data[7];
endmodule

// File: doc/demux8x32_buf.md
# demux8x32_buf

Registered 1-to-8 demultiplexer for 32-bit words: the routing counterpart of the 8-to-1 selector. It accepts one word per cycle from a single producer over a valid/ready handshake. It steers the word by `SEL` into one of eight one-entry output holding registers, each drained by its own consumer over a per-channel valid/ready handshake. It sits on the write-back/fan-out side of the datapath, where one result bus feeds several independent sinks.

## Interface
Parameters:
- `WIDTH`, 32, data word width.
- `CNT_W`, 16, width of the accepted-word counter.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: producer presents a word.
- `in_ready` output 1: block will accept the word this cycle.
- `SEL` input 3: destination channel index, 0..7.
- `data_in` input WIDTH: word to route.
- `out_valid` output 8: bit k means channel k holds a word.
- `out_ready` input 8: bit k means consumer k takes channel k's word this cycle.
- `data_out0` .. `data_out7` output WIDTH each: holding register of channel k.
- `accept_count` output CNT_W: number of words accepted since reset, modulo 2^CNT_W.

## Operation
- **Per-channel state.** Each channel k has a holding register `data_outk` and a flag `out_valid[k]`.
- **Drain event.** `drain[k] = out_valid[k] & out_ready[k]`.
- **Ready.** `in_ready = ~out_valid[SEL] | out_ready[SEL]`. It is combinational from `SEL`, `out_valid` and `out_ready` only, and never depends on `in_valid`.
- **Accept event.** `acc = in_valid & in_ready`.
- **Channel update, per k, each edge:**
  - `acc & SEL==k`: `data_outk <= data_in`, `out_valid[k] <= 1`. This covers a simultaneous drain of k: the new word replaces the drained one and valid stays 1.
  - else if `drain[k]`: `out_valid[k] <= 0`; `data_outk` holds its last value.
  - else: hold.
- **Independent channels.**
  - Any number of channels may drain in the same cycle as each other and as one accept.
  - A drain of channel j does not affect acceptance into channel k≠j.
- **Counter.** `accept_count` increments by 1 on every accept. It wraps from 2^CNT_W−1 to 0 with no flag.
- **Producer rule.** While `in_valid & ~in_ready`, the producer holds `SEL` and `data_in` stable. The block does not check this rule.
- **Consumer rule.** `out_ready[k]` while `out_valid[k]==0` has no effect.
- **No reordering within a channel.** Each channel holds at most one word. Words routed to the same channel are delivered in acceptance order.

## Timing
- **Reset values.** While `rst` is high, and immediately on its assertion:
  - `out_valid = 8'h00`
  - all `data_outk = 0`
  - `accept_count = 0`
  - `in_ready` then evaluates to 1.
- **Reset mid-operation.** Words held when `rst` asserts are discarded and not delivered.
- **First edge after reset.** The first rising edge after `rst` deasserts may accept a word.
- **Latency.** A word accepted at edge N appears on `data_outk` with `out_valid[k]=1` after edge N, i.e. one cycle of latency. It is consumable at edge N+1 at the earliest.
- **Throughput.**
  - One word per cycle into a single channel whose consumer holds `out_ready[k]=1`.
  - One word per cycle spread across different channels regardless of consumers, until the target channel is full.
- **Backpressure.** If channel `SEL` is full and not draining, `in_ready=0`. No state changes for that request and `accept_count` does not change.
- **Invalid `SEL`.** When `in_valid=0`, `SEL` is don't-care and no channel is written.

## Test plan
- **Reset.** Assert `rst` mid-run while channels 2 and 5 are valid → `out_valid=0x00`, `data_out2=data_out5=0`, `accept_count=0` asynchronously, before the next edge; `in_ready=1`.
- **Single route.** Send `SEL=3`, `data_in=0xDEADBEEF`, `in_valid=1` for one cycle with `out_ready=0` → after the edge `out_valid=0x08`, `data_out3=0xDEADBEEF`, `accept_count=1`, other channels unchanged.
- **Backpressure.** With channel 3 full and `out_ready[3]=0`, present `SEL=3`, `data_in=0x12345678` → `in_ready=0` for 4 cycles with no change. Raise `out_ready[3]` → same-cycle accept and drain; `data_out3=0x12345678`, `out_valid[3]` stays 1, `accept_count=2`.
- **Parallel.** Stream `SEL=0..7` with data `0x100+k`, then drain all 8 with `out_ready=0xFF` in one cycle → `out_valid` goes 0x01, 0x03, …, 0xFF on consecutive edges. Each `data_outk=0x100+k`. After the drain cycle `out_valid=0x00`.
- **Streaming.** Send 20 back-to-back words to channel 6 with `out_ready[6]=1` → `in_ready` stays 1 throughout. The consumer sees all 20 words in order, one per cycle, and `accept_count=20`.
- **Wrap.** With `CNT_W=4`, accept 17 words → `accept_count` reads 0xF after 15 accepts, 0x0 after 16, and 0x1 after 17.
